pgs_pciex4_fifo_rd_stage: RTL and testbench

//  Read-side output stage of the PCIe x4 DMA FIFO. Sits downstream of the FIFO

---
 rtl/pgs_pciex4_fifo_pkg.sv | 26 ++
 rtl/pgs_pciex4_fifo_rd_stage_if.sv | 12 +
 rtl/pgs_pciex4_rd_lat_pipe.sv | 43 ++++
 rtl/pgs_pciex4_fifo_rd_stage.sv | 121 ++++++++++++
 tb/tb_pgs_pciex4_fifo_rd_stage.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pgs_pciex4_fifo_pkg.sv
// Shared types, constants and helpers for the PCIe x4 DMA FIFO read stage.
// Pointer and counter widths are sized for the largest legal read latency.
package pgs_pciex4_fifo_pkg;

   localparam int ERR_OVF_BIT = 0;
   localparam int ERR_UNF_BIT = 1;
   localparam int MAX_RD_LAT  = 2;

   function automatic int buf_depth(input int rd_lat);
      return rd_lat + 2;
   endfunction

   function automatic int clog2(input int val);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < val) r = i + 1;
      end
      return r;
   endfunction

   localparam int MAX_DEPTH = buf_depth(MAX_RD_LAT);
   localparam int PTR_W     = clog2(MAX_DEPTH);
   localparam int CNT_W     = clog2(MAX_DEPTH + 1);

endpackage

// File: rtl/pgs_pciex4_fifo_rd_stage_if.sv
// Valid/ready word stream from the FIFO read stage to the DMA TLP builder.
// master drives valid/data, slave drives ready.
interface pgs_pciex4_fifo_rd_stage_if #(
   parameter int DATA_WIDTH = 128
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pgs_pciex4_rd_lat_pipe.sv
// Tracks issued RAM reads across the fixed read latency: the tail bit marks the
// cycle ram_rd_data carries a requested word, the popcount gives reads in flight.
module pgs_pciex4_rd_lat_pipe
   import pgs_pciex4_fifo_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_i,
   output logic             capture_o,
   output logic [CNT_W-1:0] inflight_o
);

   logic [LAT-1:0] vld_q;

   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (rst) vld_q[gi] <= 1'b0;
               else     vld_q[gi] <= issue_i;
            end
         end else begin : g_body
            always_ff @(posedge clk) begin
               if (rst) vld_q[gi] <= 1'b0;
               else     vld_q[gi] <= vld_q[gi-1];
            end
         end
      end
   endgenerate

   assign capture_o = vld_q[LAT-1];

   always_comb begin
      inflight_o = '0;
      for (int i = 0; i < LAT; i++) begin
         inflight_o = inflight_o + CNT_W'(vld_q[i]);
      end
   end

endmodule

// File: rtl/pgs_pciex4_fifo_rd_stage.sv
// FWFT read stage: prefetches RAM words into a RD_LATENCY+2 entry skid buffer.
// Optional sticky overflow/underflow flags are built only with PGS_FIFO_RD_ERR_EN.
module pgs_pciex4_fifo_rd_stage
   import pgs_pciex4_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int RD_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        fifo_rempty_i,
   output logic                        fifo_r_en_o,
   input  logic [DATA_WIDTH-1:0]       ram_rd_data_i,
   pgs_pciex4_fifo_rd_stage_if.master  m_if,
   output logic [1:0]                  err_flags_o
);

   localparam int               BUF_DEPTH = buf_depth(RD_LATENCY);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_W:0]   DEPTH_W   = (CNT_W + 1)'(BUF_DEPTH);

   logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

   logic                  r_en;
   logic                  capture;
   logic                  cap_acc;
   logic                  pop;
   logic [CNT_W-1:0]      inflight;
   logic [CNT_W:0]        credit_sum;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   pgs_pciex4_rd_lat_pipe #(
      .LAT (RD_LATENCY)
   ) u_lat_pipe (
      .clk        (clk),
      .rst        (rst),
      .issue_i    (r_en),
      .capture_o  (capture),
      .inflight_o (inflight)
   );

   // Reads already in flight reserve a slot, so a capture always finds room.
   assign pop        = m_valid_q & m_if.ready;
   assign credit_sum = {1'b0, cnt_q} + {1'b0, inflight} - {{CNT_W{1'b0}}, pop};
   assign r_en       = ~fifo_rempty_i & (credit_sum < DEPTH_W);
   assign fifo_r_en_o = r_en;

`ifdef PGS_FIFO_RD_ERR_EN
   logic       ovf;
   logic [1:0] err_q;

   assign ovf     = capture & (cnt_q == CNT_W'(BUF_DEPTH)) & ~pop;
   assign cap_acc = capture & ~ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 2'b00;
      end else begin
         if (ovf)                  err_q[ERR_OVF_BIT] <= 1'b1;
         if (r_en & fifo_rempty_i) err_q[ERR_UNF_BIT] <= 1'b1;
      end
   end

   assign err_flags_o = err_q;
`else
   assign cap_acc = capture;

   always_comb begin
      err_flags_o              = 2'b00;
      err_flags_o[ERR_OVF_BIT] = 1'b0;
      err_flags_o[ERR_UNF_BIT] = 1'b0;
   end
`endif

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      m_data_d = m_data_q;
      if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
      if (cap_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      cnt_d = cnt_q + CNT_W'(cap_acc) - CNT_W'(pop);
      // A word landing in an otherwise-empty buffer becomes the head directly.
      if (cap_acc && (cnt_q == CNT_W'(pop))) begin
         m_data_d = ram_rd_data_i;
      end else if (cnt_d != '0) begin
         m_data_d = buf_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         m_valid_q <= (cnt_d != '0);
         m_data_q  <= m_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && cap_acc) buf_q[wr_ptr_q] <= ram_rd_data_i;
   end

   assign m_if.valid = m_valid_q;
   assign m_if.data  = m_data_q;

endmodule

// File: tb/tb_pgs_pciex4_fifo_rd_stage.sv
// Bench for pgs_pciex4_fifo_rd_stage: one instance per legal RD_LATENCY, each fed by
// a FIFO/RAM model; scenario table plus hand sequences for reset, random ready, errors.
module tb_pgs_pciex4_fifo_rd_stage;

   localparam int DW = 32;

   typedef struct {
      int ch;
      int nwords;
      int stall;
      int exp_first;
      int exp_ren_stall;
   } vec_t;

   logic clk;
   logic rst;

   logic          rdy      [2];
   logic          ren_w    [2];
   logic          rempty_w [2];
   logic          valid_w  [2];
   logic [DW-1:0] data_w   [2];
   logic [1:0]    err_w    [2];

   int            fill     [2];
   int            raddr    [2];
   logic [7:0]    tag      [2];
   logic [DW-1:0] p1       [2];
   logic [DW-1:0] p2;

   int            exp_idx  [2];
   int            ren_cnt  [2];
   logic          hold_prev[2];
   logic [DW-1:0] prev_data[2];
   logic          popped   [2];
   logic          mon_en;
   logic [7:0]    tag_next;

   int checks;
   int failures;

   logic          ren1, ren2;
   logic [1:0]    err1, err2;

   pgs_pciex4_fifo_rd_stage_if #(.DATA_WIDTH(DW)) mif1 ();
   pgs_pciex4_fifo_rd_stage_if #(.DATA_WIDTH(DW)) mif2 ();

   pgs_pciex4_fifo_rd_stage #(.DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
      .clk           (clk),
      .rst           (rst),
      .fifo_rempty_i (rempty_w[0]),
      .fifo_r_en_o   (ren1),
      .ram_rd_data_i (p1[0]),
      .m_if          (mif1),
      .err_flags_o   (err1)
   );

   pgs_pciex4_fifo_rd_stage #(.DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut2 (
      .clk           (clk),
      .rst           (rst),
      .fifo_rempty_i (rempty_w[1]),
      .fifo_r_en_o   (ren2),
      .ram_rd_data_i (p2),
      .m_if          (mif2),
      .err_flags_o   (err2)
   );

   assign mif1.ready = rdy[0];
   assign mif2.ready = rdy[1];
   assign ren_w[0]   = ren1;
   assign ren_w[1]   = ren2;
   assign valid_w[0] = mif1.valid;
   assign valid_w[1] = mif2.valid;
   assign data_w[0]  = mif1.data;
   assign data_w[1]  = mif2.data;
   assign err_w[0]   = err1;
   assign err_w[1]   = err2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] word(input logic [7:0] t, input int idx);
      return {t, idx[23:0]};
   endfunction

   // FIFO controller + RAM model: word at address a is {tag, a}.
   always_comb begin
      for (int c = 0; c < 2; c++) rempty_w[c] = (raddr[c] >= fill[c]);
   end

   always @(posedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (rst)           raddr[c] <= 0;
         else if (ren_w[c]) raddr[c] <= raddr[c] + 1;
         p1[c] <= word(tag[c], raddr[c]);
      end
      p2 <= p1[1];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called #1 after a negedge with this cycle's inputs applied.
   task automatic monitor();
      for (int c = 0; c < 2; c++) begin
         popped[c] = 1'b0;
         if (mon_en && !rst) begin
            chk("ren_while_empty", 32'(ren_w[c] & rempty_w[c]), 32'd0);
            if (ren_w[c]) ren_cnt[c]++;
            if (hold_prev[c]) begin
               chk("stall_valid_held", 32'(valid_w[c]), 32'd1);
               chk("stall_data_stable", data_w[c], prev_data[c]);
            end
            if (valid_w[c] && rdy[c]) begin
               chk("beat_data", data_w[c], word(tag[c], exp_idx[c]));
               $display("ch%0d beat %0d data=%08h", c, exp_idx[c], data_w[c]);
               exp_idx[c]++;
               popped[c] = 1'b1;
            end
            hold_prev[c] = valid_w[c] && !rdy[c];
            prev_data[c] = data_w[c];
         end
      end
   endtask

   task automatic cycle();
      #1;
      monitor();
      @(negedge clk);
   endtask

   task automatic clear_state();
      for (int c = 0; c < 2; c++) begin
         exp_idx[c]   = 0;
         ren_cnt[c]   = 0;
         hold_prev[c] = 1'b0;
         popped[c]    = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      fill[0] = 0;
      fill[1] = 0;
      rdy[0]  = 1'b0;
      rdy[1]  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      clear_state();
   endtask

   task automatic run_vec(input vec_t v);
      int first_k, beat_first, beat_last, ren_stall, k, c;
      c = v.ch;
      do_reset();
      tag_next++;
      tag[c]  = tag_next;
      rdy[c]  = (v.stall == 0);
      fill[c] = v.nwords;
      first_k = -1; beat_first = -1; beat_last = -1; ren_stall = 0;
      for (k = 0; (k < v.nwords + v.stall + 20) && (exp_idx[c] < v.nwords); k++) begin
         if (v.stall > 0 && k == v.stall) rdy[c] = 1'b1;
         #1;
         monitor();
         if (first_k < 0 && valid_w[c]) first_k = k;
         if (k < v.stall && ren_w[c]) ren_stall++;
         if (popped[c]) begin
            if (beat_first < 0) beat_first = k;
            beat_last = k;
         end
         @(negedge clk);
      end
      $display("vec ch%0d n=%0d stall=%0d first=%0d ren_stall=%0d beats=%0d",
               c, v.nwords, v.stall, first_k, ren_stall, beat_last - beat_first + 1);
      chk("first_valid_latency", first_k, v.exp_first);
      if (v.stall > 0) chk("ren_under_stall", ren_stall, v.exp_ren_stall);
      chk("gap_free_beats", beat_last - beat_first + 1, v.nwords);
      chk("words_delivered", exp_idx[c], v.nwords);
      repeat (3) cycle();
      chk("total_ren", ren_cnt[c], v.nwords);
      chk("idle_valid", 32'(valid_w[c]), 32'd0);
      chk("err_flags", 32'(err_w[c]), 32'd0);
   endtask

   vec_t vecs [4];

   initial begin
      checks   = 0;
      failures = 0;
      mon_en   = 1'b1;
      tag_next = 8'h10;
      tag[0]   = 8'h01;
      tag[1]   = 8'h02;
      clear_state();

      vecs[0] = '{ch: 0, nwords: 16, stall: 0,  exp_first: 2, exp_ren_stall: 0};
      vecs[1] = '{ch: 0, nwords: 16, stall: 20, exp_first: 2, exp_ren_stall: 3};
      vecs[2] = '{ch: 1, nwords: 16, stall: 0,  exp_first: 3, exp_ren_stall: 0};
      vecs[3] = '{ch: 1, nwords: 16, stall: 20, exp_first: 3, exp_ren_stall: 4};

      // Reset/idle: reset held 3 clks with the FIFO empty, then released.
      rst = 1'b1; fill[0] = 0; fill[1] = 0; rdy[0] = 1'b0; rdy[1] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 3) rst = 1'b0;
         #1;
         for (int c = 0; c < 2; c++) begin
            chk("idle_ren", 32'(ren_w[c]), 32'd0);
            chk("idle_m_valid", 32'(valid_w[c]), 32'd0);
            chk("idle_m_data", data_w[c], 32'd0);
            chk("idle_err", 32'(err_w[c]), 32'd0);
         end
         $display("idle cycle %0d rst=%0b ren=%0b/%0b valid=%0b/%0b", i, rst,
                  ren_w[0], ren_w[1], valid_w[0], valid_w[1]);
      end

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Random 50% ready on the depth-3 instance: exercises pointer wrap.
      do_reset();
      tag_next++;
      tag[0]  = tag_next;
      fill[0] = 100;
      for (int k = 0; k < 600 && exp_idx[0] < 100; k++) begin
         rdy[0] = 1'($urandom_range(0, 1));
         cycle();
      end
      chk("rand_words_delivered", exp_idx[0], 32'd100);
      chk("rand_total_ren", ren_cnt[0], 32'd100);

      // Reset with two reads in flight on the latency-2 instance.
      do_reset();
      tag_next++;
      tag[1]  = tag_next;
      rdy[1]  = 1'b1;
      fill[1] = 16;
      repeat (6) cycle();
      chk("pre_rst_inflight", 32'(u_dut2.inflight), 32'd2);
      rst     = 1'b1;
      fill[0] = 0;
      fill[1] = 0;
      @(negedge clk);
      #1;
      chk("rst_valid_drop", 32'(valid_w[1]), 32'd0);
      $display("mid-stream rst: valid=%0b", valid_w[1]);
      @(negedge clk);
      rst = 1'b0;
      clear_state();
      tag_next++;
      tag[1] = tag_next;
      rdy[1] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("post_rst_no_stale", 32'(valid_w[1]), 32'd0);
         @(negedge clk);
      end
      fill[1] = 4;
      for (int k = 0; k < 20 && exp_idx[1] < 4; k++) cycle();
      chk("post_rst_words", exp_idx[1], 32'd4);

`ifdef PGS_FIFO_RD_ERR_EN
      do_reset();
      mon_en = 1'b0;
      force u_dut1.r_en = 1'b1;
      @(negedge clk);
      release u_dut1.r_en;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("err_underflow_sticky", 32'(err_w[0]), 32'd2);
         @(negedge clk);
      end
      do_reset();
      mon_en = 1'b1;
      #1;
      chk("err_cleared_by_rst", 32'(err_w[0]), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
